spi_arbiter: RTL and testbench

Shares the single `chameleon2_spi` byte engine between several toggle-handshake requesters: the flash loader, the MMC64 SD interface and the RTC. It replaces the hard `rom_load_done` mux in the top level. Each requester owns the bus for a complete chip-select transaction, and no other requester's bytes may be interleaved into it. The arbiter drives the per-device chip-select pins.

---
 rtl/spi_arbiter_pkg.sv | 26 ++
 rtl/spi_arbiter_rr_pick.sv | 27 ++
 rtl/spi_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_spi_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arbiter_pkg.sv
// Shared types and constants for the SPI requester arbiter.
package spi_arbiter_pkg;

  localparam int unsigned MAX_REQUESTERS = 4;
  localparam int unsigned GAP_CNT_W      = 4;
  localparam int unsigned IDX_W          = 2;

  // Arbiter FSM states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  typedef logic [1:0] arb_state_t;

  // Index of the set bit in a one-hot vector (0 when empty).
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQUESTERS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQUESTERS; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, with wrap.
module rr_pick
  import spi_arbiter_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic             valid_o
);

  // Scan offsets from the pointer; the first hit wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!valid_o && req_i[i] && (i == (32'(ptr_i) + off) % N)) begin
          grant_o[i] = 1'b1;
          valid_o    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one toggle-handshake SPI byte engine between several requesters,
// holding each owner's chip select for a whole transaction.
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int unsigned requesters    = 2,
  parameter int unsigned cs_gap_cycles = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [requesters-1:0]   m_req,
  output logic [requesters-1:0]   m_ack,
  input  logic [8*requesters-1:0] m_d,
  input  logic [requesters-1:0]   m_speed,
  input  logic [requesters-1:0]   m_cs,
  output logic [requesters-1:0]   m_grant,
  output logic [7:0]              m_q,
  output logic                    spi_req,
  input  logic                    spi_ack,
  output logic [7:0]              spi_d,
  output logic                    spi_speed,
  input  logic [7:0]              spi_q,
  output logic [requesters-1:0]   cs_n
);

  localparam int unsigned N        = requesters;
  localparam int unsigned GAP_LAST = (cs_gap_cycles > 0) ? cs_gap_cycles - 1 : 0;

  arb_state_t           state_q,     state_d;
  logic [IDX_W-1:0]     owner_q,     owner_d;
  logic [IDX_W-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [GAP_CNT_W-1:0] gap_cnt_q,   gap_cnt_d;
  logic [N-1:0]         grant_q,     grant_d;
  logic [N-1:0]         cs_n_q,      cs_n_d;
  logic [N-1:0]         ack_q,       ack_d;
  logic                 spi_req_q,   spi_req_d;
  logic [7:0]           spi_d_q,     spi_d_d;
  logic                 spi_speed_q, spi_speed_d;
  logic [7:0]           m_q_q,       m_q_d;

  logic [N-1:0]         pending;
  logic [N-1:0]         cand;
  logic [N-1:0]         pick_grant;
  logic                 pick_valid;
  logic [IDX_W-1:0]     win_idx;
  logic                 own_pend;
  logic                 own_cs;
  logic                 own_speed;
  logic [7:0]           own_d;

  assign pending = m_req ^ ack_q;
  assign cand    = pending | m_cs;

  rr_pick #(.N(N)) u_rr_pick (
    .req_i   (cand),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .valid_o (pick_valid)
  );

  assign win_idx = onehot_to_idx(MAX_REQUESTERS'(pick_grant));

  // Select the current owner's request, CS, speed and data.
  always_comb begin
    own_pend  = 1'b0;
    own_cs    = 1'b0;
    own_speed = 1'b0;
    own_d     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (owner_q == IDX_W'(i)) begin
        own_pend  = pending[i];
        own_cs    = m_cs[i];
        own_speed = m_speed[i];
        own_d     = m_d[8*i +: 8];
      end
    end
  end

  // Next-state and output logic for the ownership FSM.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    gap_cnt_d   = gap_cnt_q;
    grant_d     = grant_q;
    cs_n_d      = cs_n_q;
    ack_d       = ack_q;
    spi_req_d   = spi_req_q;
    spi_d_d     = spi_d_q;
    spi_speed_d = spi_speed_q;
    m_q_d       = m_q_q;

    case (state_q)
      S_IDLE: begin
        spi_speed_d = 1'b0;
        if (pick_valid) begin
          state_d     = S_OWN;
          owner_d     = win_idx;
          grant_d     = pick_grant;
          cs_n_d      = ~pick_grant;
          rr_ptr_d    = IDX_W'((32'(win_idx) + 32'd1) % N);
          spi_speed_d = |(pick_grant & m_speed);
        end
      end

      S_OWN: begin
        // A pending byte beats a CS drop: send it, then release.
        if (own_pend) begin
          state_d     = S_XFER;
          spi_d_d     = own_d;
          spi_speed_d = own_speed;
          spi_req_d   = ~spi_req_q;
        end else if (!own_cs) begin
          state_d     = S_GAP;
          grant_d     = '0;
          cs_n_d      = '1;
          gap_cnt_d   = '0;
          spi_speed_d = 1'b0;
        end else begin
          spi_speed_d = own_speed;
        end
      end

      S_XFER: begin
        if (spi_ack == spi_req_q) begin
          state_d = S_OWN;
          m_q_d   = spi_q;
          for (int unsigned i = 0; i < N; i++) begin
            if (owner_q == IDX_W'(i)) ack_d[i] = m_req[i];
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_CNT_W'(GAP_LAST)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset discards stale requests and any byte in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      gap_cnt_q   <= '0;
      grant_q     <= '0;
      cs_n_q      <= '1;
      ack_q       <= m_req;
      spi_req_q   <= spi_ack;
      spi_d_q     <= 8'h00;
      spi_speed_q <= 1'b0;
      m_q_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      gap_cnt_q   <= gap_cnt_d;
      grant_q     <= grant_d;
      cs_n_q      <= cs_n_d;
      ack_q       <= ack_d;
      spi_req_q   <= spi_req_d;
      spi_d_q     <= spi_d_d;
      spi_speed_q <= spi_speed_d;
      m_q_q       <= m_q_d;
    end
  end

  assign m_ack     = ack_q;
  assign m_grant   = grant_q;
  assign cs_n      = cs_n_q;
  assign m_q       = m_q_q;
  assign spi_req   = spi_req_q;
  assign spi_d     = spi_d_q;
  assign spi_speed = spi_speed_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with two requesters and a simple SPI engine model.
module tb_spi_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  m_req;
  logic [1:0]  m_ack;
  logic [15:0] m_d;
  logic [1:0]  m_speed;
  logic [1:0]  m_cs;
  logic [1:0]  m_grant;
  logic [7:0]  m_q;
  logic        spi_req;
  logic        spi_ack;
  logic [7:0]  spi_d;
  logic        spi_speed;
  logic [7:0]  spi_q;
  logic [1:0]  cs_n;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  resp     = 8'h00;
  int          mcnt     = 0;

  spi_arbiter #(.requesters(2), .cs_gap_cycles(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m_req     (m_req),
    .m_ack     (m_ack),
    .m_d       (m_d),
    .m_speed   (m_speed),
    .m_cs      (m_cs),
    .m_grant   (m_grant),
    .m_q       (m_q),
    .spi_req   (spi_req),
    .spi_ack   (spi_ack),
    .spi_d     (spi_d),
    .spi_speed (spi_speed),
    .spi_q     (spi_q),
    .cs_n      (cs_n)
  );

  always #5 clk = ~clk;

  // SPI engine model: answers a toggled request after 10 cycles with resp.
  always begin
    @(posedge clk);
    #2;
    if (reset_n === 1'b1 && spi_req !== spi_ack) begin
      mcnt++;
      if (mcnt >= 10) begin
        spi_q   = resp;
        spi_ack = spi_req;
        mcnt    = 0;
      end
    end else begin
      mcnt = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m_req   = 2'b10;
    m_d     = '0;
    m_speed = '0;
    m_cs    = '0;
    tick(3);
    checks++; if (cs_n !== 2'b11) begin failures++; $display("FAIL reset_cs_n got=%b exp=11", cs_n); end
    checks++; if (m_grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", m_grant); end
    checks++; if (m_ack !== 2'b10) begin failures++; $display("FAIL reset_ack got=%b exp=10", m_ack); end
    checks++; if (spi_req !== 1'b0) begin failures++; $display("FAIL reset_spi_req got=%b exp=0", spi_req); end
    checks++; if (spi_d !== 8'h00) begin failures++; $display("FAIL reset_spi_d got=%h exp=00", spi_d); end
    checks++; if (spi_speed !== 1'b0) begin failures++; $display("FAIL reset_spi_speed got=%b exp=0", spi_speed); end
    checks++; if (m_q !== 8'h00) begin failures++; $display("FAIL reset_m_q got=%h exp=00", m_q); end
    reset_n = 1'b1;
    tick(3);
    checks++; if (m_grant !== 2'b00) begin failures++; $display("FAIL reset_stale_grant got=%b exp=00", m_grant); end
  endtask

  task automatic test_single_byte();
    int t;
    int hi;
    resp      = 8'h3C;
    m_cs      = 2'b00;
    m_d[7:0]  = 8'hA5;
    m_req[0]  = ~m_req[0];
    t = 0;
    while (m_grant === 2'b00 && t < 10) begin tick(); t++; end
    checks++; if (t >= 10) begin failures++; $display("FAIL single_grant_timeout got=%b exp=01", m_grant); end
    checks++; if (cs_n !== 2'b10) begin failures++; $display("FAIL single_cs_n got=%b exp=10", cs_n); end
    t = 0;
    while (spi_req === spi_ack && t < 10) begin tick(); t++; end
    checks++; if (spi_d !== 8'hA5) begin failures++; $display("FAIL single_spi_d got=%h exp=a5", spi_d); end
    checks++; if (spi_speed !== 1'b0) begin failures++; $display("FAIL single_spi_speed got=%b exp=0", spi_speed); end
    t = 0;
    while (m_ack[0] !== m_req[0] && t < 40) begin tick(); t++; end
    checks++; if (m_q !== 8'h3C) begin failures++; $display("FAIL single_m_q got=%h exp=3c", m_q); end
    checks++; if (cs_n !== 2'b10) begin failures++; $display("FAIL single_cs_hold got=%b exp=10", cs_n); end
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cs_n === 2'b11 && m_grant === 2'b00) hi++;
    end
    checks++; if (hi != 4) begin failures++; $display("FAIL single_gap got=%0d exp=4", hi); end
    tick(4);
  endtask

  task automatic test_locked();
    logic [7:0] bytes [3];
    int t;
    int bad;
    int hi;
    bytes[0] = 8'h10;
    bytes[1] = 8'h20;
    bytes[2] = 8'h30;
    resp     = 8'h81;
    m_cs[0]  = 1'b1;
    bad      = 0;
    for (int b = 0; b < 3; b++) begin
      m_d[7:0] = bytes[b];
      m_req[0] = ~m_req[0];
      if (b == 1) begin
        m_d[15:8] = 8'h5A;
        m_req[1]  = ~m_req[1];
      end
      t = 0;
      while (m_ack[0] !== m_req[0] && t < 60) begin
        tick();
        t++;
        if (m_grant !== 2'b01 || (spi_req !== spi_ack && spi_d !== bytes[b])) bad++;
      end
      checks++; if (t >= 60) begin failures++; $display("FAIL locked_byte_timeout got=%0d exp=<60", t); end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL locked_interleave got=%0d exp=0", bad); end
    checks++; if (m_ack[1] === m_req[1]) begin failures++; $display("FAIL locked_r1_pending got=%b exp=%b", m_ack[1], ~m_req[1]); end
    checks++; if (cs_n !== 2'b10) begin failures++; $display("FAIL locked_cs_n got=%b exp=10", cs_n); end
    m_cs[0] = 1'b0;
    hi = 0;
    t  = 0;
    while (spi_req === spi_ack && t < 30) begin
      tick();
      t++;
      if (cs_n === 2'b11) hi++;
    end
    checks++; if (hi != 5) begin failures++; $display("FAIL locked_gap got=%0d exp=5", hi); end
    checks++; if (spi_d !== 8'h5A) begin failures++; $display("FAIL locked_r1_spi_d got=%h exp=5a", spi_d); end
    checks++; if (m_grant !== 2'b10 || cs_n !== 2'b01) begin failures++; $display("FAIL locked_r1_grant got=%b/%b exp=10/01", m_grant, cs_n); end
    t = 0;
    while (m_ack[1] !== m_req[1] && t < 40) begin tick(); t++; end
    checks++; if (m_q !== 8'h81) begin failures++; $display("FAIL locked_r1_m_q got=%h exp=81", m_q); end
    tick(8);
  endtask

  task automatic test_round_robin();
    int t;
    int n;
    logic [1:0] prev;
    logic [1:0] ord0;
    logic [1:0] ord1;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    resp = 8'h44;
    m_cs = 2'b00;
    m_d  = {8'h22, 8'h11};
    for (int r = 0; r < 2; r++) begin
      m_req = ~m_req;
      n = 0; prev = 2'b00; ord0 = 2'b00; ord1 = 2'b00; t = 0;
      while (m_ack !== m_req && t < 120) begin
        tick();
        t++;
        if (m_grant !== 2'b00 && prev === 2'b00) begin
          if (n == 0) ord0 = m_grant;
          else if (n == 1) ord1 = m_grant;
          n++;
        end
        prev = m_grant;
      end
      checks++; if (t >= 120) begin failures++; $display("FAIL rr_timeout round=%0d got=%b exp=%b", r, m_ack, m_req); end
      checks++; if (ord0 !== 2'b01) begin failures++; $display("FAIL rr_first round=%0d got=%b exp=01", r, ord0); end
      checks++; if (ord1 !== 2'b10) begin failures++; $display("FAIL rr_second round=%0d got=%b exp=10", r, ord1); end
      tick(8);
    end
  endtask

  task automatic test_reset_mid_xfer();
    int t;
    resp      = 8'hEE;
    m_cs      = 2'b00;
    m_d[15:8] = 8'h77;
    m_req[1]  = ~m_req[1];
    t = 0;
    while (!(spi_req !== spi_ack && m_grant === 2'b10) && t < 20) begin tick(); t++; end
    checks++; if (t >= 20) begin failures++; $display("FAIL rst_xfer_timeout got=%b exp=10", m_grant); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++; if (cs_n !== 2'b11) begin failures++; $display("FAIL rst_xfer_cs_n got=%b exp=11", cs_n); end
    checks++; if (m_grant !== 2'b00) begin failures++; $display("FAIL rst_xfer_grant got=%b exp=00", m_grant); end
    checks++; if (spi_req !== spi_ack) begin failures++; $display("FAIL rst_xfer_spi_req got=%b exp=%b", spi_req, spi_ack); end
    checks++; if (m_ack !== m_req) begin failures++; $display("FAIL rst_xfer_ack got=%b exp=%b", m_ack, m_req); end
    tick(20);
    checks++; if (m_q !== 8'h00) begin failures++; $display("FAIL rst_xfer_spurious_m_q got=%h exp=00", m_q); end
    checks++; if (m_ack !== m_req || spi_req !== spi_ack) begin failures++; $display("FAIL rst_xfer_quiet got=%b/%b exp=%b/%b", m_ack, spi_req, m_req, spi_ack); end
  endtask

  task automatic test_speed_cs_only();
    int t;
    m_speed[1] = 1'b1;
    m_cs[1]    = 1'b1;
    t = 0;
    while (m_grant === 2'b00 && t < 10) begin tick(); t++; end
    checks++; if (m_grant !== 2'b10 || cs_n !== 2'b01) begin failures++; $display("FAIL speed_cs_grant got=%b/%b exp=10/01", m_grant, cs_n); end
    tick(3);
    checks++; if (m_grant !== 2'b10 || spi_req !== spi_ack) begin failures++; $display("FAIL speed_cs_hold got=%b/%b exp=10/%b", m_grant, spi_req, spi_ack); end
    resp      = 8'h5C;
    m_d[15:8] = 8'hFF;
    m_req[1]  = ~m_req[1];
    t = 0;
    while (spi_req === spi_ack && t < 10) begin tick(); t++; end
    checks++; if (spi_speed !== 1'b1) begin failures++; $display("FAIL speed_fast got=%b exp=1", spi_speed); end
    checks++; if (spi_d !== 8'hFF) begin failures++; $display("FAIL speed_spi_d got=%h exp=ff", spi_d); end
    t = 0;
    while (m_ack[1] !== m_req[1] && t < 40) begin tick(); t++; end
    checks++; if (m_q !== 8'h5C) begin failures++; $display("FAIL speed_m_q got=%h exp=5c", m_q); end
    m_cs[1] = 1'b0;
    t = 0;
    while (cs_n !== 2'b11 && t < 10) begin tick(); t++; end
    checks++; if (spi_speed !== 1'b0 || m_grant !== 2'b00) begin failures++; $display("FAIL speed_release got=%b/%b exp=0/00", spi_speed, m_grant); end
  endtask

  initial begin
    spi_ack = 1'b0;
    spi_q   = 8'h00;
    test_reset();
    test_single_byte();
    test_locked();
    test_round_robin();
    test_reset_mid_xfer();
    test_speed_cs_only();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
